// File: rtl/spi_adc_sequencer.sv
// Purpose : sequences amplifier-gain writes and periodic ADC conversions on the
//           preamp/ADC SPI segment and presents captured samples downstream.
// Latency : sample_valid rises one cycle after the cycle spi_init_done is high;
//           Init rises two cycles after a tick or gain request is taken.
// Backpr. : one-deep valid/ready output register; a capture that meets an
//           unconsumed sample is dropped and flags overrun (sticky).
// Ports   : clk/rst (async active-low); enable, gain_update control;
//           spi_init/spi_amp_adc/spi_init_done/spi_data to the SPI segment;
//           sample_data/sample_valid/sample_ready downstream;
//           busy, overrun, timeout_err status.
module spi_adc_sequencer #(
  parameter int SAMPLE_DIV   = 1000,
  parameter int DONE_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       gain_update,
  output logic       spi_init,
  output logic       spi_amp_adc,
  input  logic       spi_init_done,
  input  logic [7:0] spi_data,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE, AMP_SETUP, AMP_RUN, WAIT_TICK, ADC_SETUP, ADC_RUN
  } state_t;

  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(DONE_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] samp_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             gain_pending;
  logic             tick_pending;

  logic in_run, tick_now, run_tmo, run_end, capture;
  logic to_idle, take_gain, take_tick, drop_tick, drop_sample, start;

  assign in_run      = (state == AMP_RUN) || (state == ADC_RUN);
  assign tick_now    = (state != IDLE) && (samp_cnt == SAMP_LAST);
  // A done on the final allowed cycle still counts as a completion.
  assign run_tmo     = in_run && !spi_init_done && (tmo_cnt == TMO_LAST);
  assign run_end     = in_run && (spi_init_done || (tmo_cnt == TMO_LAST));
  assign capture     = (state == ADC_RUN) && spi_init_done;
  assign start       = (state == IDLE) && enable;
  assign to_idle     = (state == WAIT_TICK) && !enable;
  assign take_gain   = (state == WAIT_TICK) && enable && gain_pending;
  assign take_tick   = (state == WAIT_TICK) && enable && !gain_pending && tick_pending;
  // A tick landing on a still-pending tick is lost, unless that pending one
  // is being consumed this very cycle.
  assign drop_tick   = tick_now && tick_pending && !take_tick && !to_idle;
  assign drop_sample = capture && sample_valid && !sample_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      spi_init     <= 1'b0;
      spi_amp_adc  <= 1'b0;
      sample_data  <= 8'h00;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      samp_cnt     <= '0;
      tmo_cnt      <= '0;
      gain_pending <= 1'b0;
      tick_pending <= 1'b0;
    end else begin
      // Sample-rate counter free-runs whenever the sequencer is active.
      if (state == IDLE || samp_cnt == SAMP_LAST) begin
        samp_cnt <= '0;
      end else begin
        samp_cnt <= samp_cnt + CNT_W'(1);
      end

      // Timeout counter only lives inside a transaction.
      if (in_run) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end else begin
        tmo_cnt <= '0;
      end

      // Pending requests; a new request in the consume cycle wins.
      if (state == IDLE || to_idle) begin
        gain_pending <= 1'b0;
        tick_pending <= 1'b0;
      end else begin
        if (gain_update) begin
          gain_pending <= 1'b1;
        end else if (take_gain) begin
          gain_pending <= 1'b0;
        end
        if (tick_now) begin
          tick_pending <= 1'b1;
        end else if (take_tick) begin
          tick_pending <= 1'b0;
        end
      end

      // Output register: replace when empty or draining this cycle.
      if (capture) begin
        if (!sample_valid || sample_ready) begin
          sample_data  <= spi_data;
          sample_valid <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      // Sticky status, cleared only when a new run starts.
      if (start) begin
        overrun <= 1'b0;
      end else if (drop_tick || drop_sample) begin
        overrun <= 1'b1;
      end
      if (start) begin
        timeout_err <= 1'b0;
      end else if (run_tmo) begin
        timeout_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          spi_init <= 1'b0;
          busy     <= 1'b0;
          if (enable) begin
            state       <= AMP_SETUP;
            spi_amp_adc <= 1'b0;
            busy        <= 1'b1;
          end
        end
        // Setup cycles hold AMP_ADC steady for a cycle before Init rises.
        AMP_SETUP: begin
          state    <= AMP_RUN;
          spi_init <= 1'b1;
        end
        ADC_SETUP: begin
          state    <= ADC_RUN;
          spi_init <= 1'b1;
        end
        AMP_RUN, ADC_RUN: begin
          if (run_end) begin
            state    <= WAIT_TICK;
            spi_init <= 1'b0;
            busy     <= 1'b0;
          end
        end
        WAIT_TICK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (gain_pending) begin
            state       <= AMP_SETUP;
            spi_amp_adc <= 1'b0;
            busy        <= 1'b1;
          end else if (tick_pending) begin
            state       <= ADC_SETUP;
            spi_amp_adc <= 1'b1;
            busy        <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          spi_init <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_sequencer.sv
// Purpose : self-checking bench for spi_adc_sequencer with a behavioural SPI
//           segment model and a sample scoreboard.
// Latency : model answers Init_Done resp_dly cycles after Init rises.
// Backpr. : bench drives sample_ready directly to exercise overrun.
module tb_spi_adc_sequencer;

  localparam int SD  = 300;
  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       gain_update = 1'b0;
  logic       spi_init;
  logic       spi_amp_adc;
  logic       spi_init_done = 1'b0;
  logic [7:0] spi_data = 8'h00;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready = 1'b1;
  logic       busy;
  logic       overrun;
  logic       timeout_err;

  spi_adc_sequencer #(.SAMPLE_DIV(SD), .DONE_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .gain_update(gain_update),
    .spi_init(spi_init), .spi_amp_adc(spi_amp_adc),
    .spi_init_done(spi_init_done), .spi_data(spi_data),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SPI segment model and scoreboard, both on the falling edge.
  logic       resp_en  = 1'b1;
  int         resp_dly = 40;
  logic [7:0] adc_val  = 8'h00;
  int         age      = 0;
  int         done_cyc = 0;
  int         vcnt     = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (spi_init) begin
      age = age + 1;
      if (resp_en && age == resp_dly) begin
        spi_init_done = 1'b1;
        spi_data      = adc_val;
        done_cyc      = cyc;
      end else begin
        spi_init_done = 1'b0;
      end
    end else begin
      age           = 0;
      spi_init_done = 1'b0;
    end
    if (sample_valid) vcnt++;
    if (sample_valid && sample_ready) begin
      if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
      else check("sample", {24'h0, sample_data}, {24'h0, exp_q.pop_front()});
    end
  end

  // Transaction monitor: logs each Init rise with its AMP_ADC level.
  logic txn_amp[$];
  int   txn_cyc[$];
  logic prev_init  = 1'b0;
  logic prev_valid = 1'b0;
  int   last_fall  = 0;
  int   vrise_cyc  = 0;

  always @(posedge clk) begin
    #1;
    if (spi_init && !prev_init) begin
      txn_amp.push_back(spi_amp_adc);
      txn_cyc.push_back(cyc);
    end
    if (!spi_init && prev_init) last_fall = cyc;
    if (sample_valid && !prev_valid) vrise_cyc = cyc;
    prev_init  = spi_init;
    prev_valid = sample_valid;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_txn(input string tag, input logic exp_amp, output int rise);
    int n = 0;
    while (txn_amp.size() == 0 && n < 800) begin
      step();
      n++;
    end
    if (txn_amp.size() == 0) begin
      check({tag, "_missing"}, txn_amp.size(), 1);
      rise = cyc;
    end else begin
      rise = txn_cyc.pop_front();
      check(tag, {31'h0, txn_amp.pop_front()}, {31'h0, exp_amp});
    end
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    while (spi_init && n < 400) begin
      step();
      n++;
    end
    check({tag, "_fall"}, {31'h0, spi_init}, 0);
  endtask

  task automatic pulse_gain();
    gain_update = 1'b1;
    step();
    gain_update = 1'b0;
  endtask

  initial begin
    int e0, r, rg, t;

    // Reset values
    #1;
    check("rst_init", {31'h0, spi_init}, 0);
    check("rst_amp", {31'h0, spi_amp_adc}, 0);
    check("rst_valid", {31'h0, sample_valid}, 0);
    check("rst_data", {24'h0, sample_data}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_flags", {30'h0, overrun, timeout_err}, 0);
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();
    check("idle_busy", {31'h0, busy}, 0);

    // Startup: amp write first, first ADC at SD+2 after enable
    enable = 1'b1;
    e0 = cyc + 1;
    wait_txn("amp_first", 1'b0, r);
    adc_val = 8'hA5;
    exp_q.push_back(8'hA5);
    vcnt = 0;
    wait_txn("adc_first", 1'b1, r);
    check("first_adc_cyc", r - e0, SD + 2);
    wait_fall("adc_a5");
    repeat (3) step();
    check("valid_pulse", vcnt, 1);
    check("cap_latency", vrise_cyc, done_cyc + 1);
    check("ovr_clean", {31'h0, overrun}, 0);
    check("data_a5", {24'h0, sample_data}, 32'hA5);

    // Backpressure across two conversions
    sample_ready = 1'b0;
    adc_val = 8'h11;
    exp_q.push_back(8'h11);
    wait_txn("adc_11", 1'b1, r);
    wait_fall("adc_11");
    adc_val = 8'h22;
    wait_txn("adc_22", 1'b1, r);
    wait_fall("adc_22");
    repeat (2) step();
    check("hold_data", {24'h0, sample_data}, 32'h11);
    check("hold_valid", {31'h0, sample_valid}, 1);
    check("ovr_set", {31'h0, overrun}, 1);
    sample_ready = 1'b1;
    repeat (2) step();
    check("drain_valid", {31'h0, sample_valid}, 0);
    check("ovr_sticky", {31'h0, overrun}, 1);

    // Gain request during ADC_RUN with a tick pending at completion
    adc_val = 8'h33;
    exp_q.push_back(8'h33);
    wait_txn("adc_33", 1'b1, rg);
    wait_fall("adc_33");
    resp_dly = 100;
    while (cyc < rg + 250) step();
    pulse_gain();
    wait_txn("gain_amp", 1'b0, r);
    wait_fall("gain_amp");
    resp_dly = 250;
    adc_val = 8'h44;
    exp_q.push_back(8'h44);
    wait_txn("adc_44", 1'b1, r);
    repeat (5) step();
    pulse_gain();
    wait_fall("adc_44");
    resp_dly = 40;
    adc_val = 8'h55;
    exp_q.push_back(8'h55);
    wait_txn("regain_amp", 1'b0, r);
    wait_fall("regain_amp");
    wait_txn("adc_55", 1'b1, r);
    check("adc_follows", r - last_fall, 2);
    wait_fall("adc_55");

    // Timeout: model never answers
    resp_en = 1'b0;
    check("tmo_clear", {31'h0, timeout_err}, 0);
    wait_txn("adc_tmo", 1'b1, t);
    wait_fall("adc_tmo");
    check("tmo_len", last_fall - t, TMO);
    check("tmo_flag", {31'h0, timeout_err}, 1);
    check("tmo_valid", {31'h0, sample_valid}, 0);
    check("tmo_data", {24'h0, sample_data}, 32'h55);
    resp_en = 1'b1;
    adc_val = 8'h66;
    exp_q.push_back(8'h66);
    wait_txn("adc_resume", 1'b1, r);
    check("resume_cyc", r - t, SD);
    wait_fall("adc_66");

    // Async reset in the middle of ADC_RUN
    resp_en = 1'b0;
    wait_txn("adc_rst", 1'b1, r);
    repeat (10) step();
    rst = 1'b0;
    #1;
    check("arst_init", {31'h0, spi_init}, 0);
    check("arst_amp", {31'h0, spi_amp_adc}, 0);
    check("arst_busy", {31'h0, busy}, 0);
    check("arst_flags", {30'h0, overrun, timeout_err}, 0);
    check("arst_valid", {31'h0, sample_valid}, 0);
    check("arst_data", {24'h0, sample_data}, 0);
    repeat (3) step();
    resp_en = 1'b1;
    resp_dly = 40;
    rst = 1'b1;
    wait_txn("rst_amp_first", 1'b0, r);

    // Stop: enable low mid-transaction, then nothing further is launched
    enable = 1'b0;
    wait_fall("stop_amp");
    repeat (3) step();
    check("stop_busy", {31'h0, busy}, 0);
    repeat (400) step();
    check("stop_no_txn", txn_amp.size(), 0);
    check("sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_adc_sequencer.md
Name: spi_adc_sequencer

Overview:
- Control stage directly upstream of the SPI segment that drives the preamp/ADC pair.
- Programs the amplifier gain once after enable and again on each gain-update request.
- Then launches ADC conversions at a fixed sample rate by driving the segment's Init/AMP_ADC inputs, and captures the 8-bit Data it returns on Init_Done.
- Presents samples to downstream logic through a valid/ready register, with sticky overrun and timeout flags.

Parameters:
- SAMPLE_DIV, 1000, clk cycles between conversion ticks (≥ 64).
- DONE_TIMEOUT, 255, max clk cycles to wait for spi_init_done before aborting a transaction.
- CNT_W, 16, width of the sample-rate and timeout counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = run sequencing, 0 = stop after the current transaction
- gain_update  in  1  one-cycle pulse requesting an amplifier re-program
- spi_init  out  1  to SPI segment Init; high for the duration of a transaction
- spi_amp_adc  out  1  to SPI segment AMP_ADC; 1 = ADC conversion (34 edges), 0 = amplifier write (8 edges)
- spi_init_done  in  1  from SPI segment Init_Done
- spi_data  in  8  from SPI segment Data
- sample_data  out  8  captured sample
- sample_valid  out  1  sample_data holds an unconsumed sample
- sample_ready  in  1  downstream accepts when sample_valid & sample_ready
- busy  out  1  FSM not in IDLE or WAIT_TICK
- overrun  out  1  sticky: a sample or tick was dropped
- timeout_err  out  1  sticky: a transaction exceeded DONE_TIMEOUT

Behaviour:
- Reset (rst=0, async): FSM=IDLE. spi_init=0, spi_amp_adc=0, sample_data=0, sample_valid=0, busy=0, overrun=0, timeout_err=0. All counters and pending flags cleared.
- All outputs are registered.
- States: IDLE, AMP_SETUP, AMP_RUN, WAIT_TICK, ADC_SETUP, ADC_RUN.
- IDLE:
  - Counters held at 0.
  - enable=1 → AMP_SETUP; overrun and timeout_err clear on this transition.
- AMP_SETUP (1 cycle): spi_amp_adc=0, spi_init=0 → AMP_RUN. AMP_ADC is stable one cycle before Init rises.
- AMP_RUN:
  - spi_init=1; timeout counter increments.
  - spi_init_done=1 → spi_init=0 next cycle, go to WAIT_TICK.
  - Timeout counter reaches DONE_TIMEOUT → spi_init=0, timeout_err=1, go to WAIT_TICK.
- WAIT_TICK:
  - enable=0 → IDLE.
  - Else if gain_pending → AMP_SETUP (clears gain_pending).
  - Else if tick_pending → ADC_SETUP (clears tick_pending).
  - Gain has priority over tick.
- ADC_SETUP (1 cycle): spi_amp_adc=1 → ADC_RUN.
- ADC_RUN:
  - spi_init=1.
  - spi_init_done=1 → capture spi_data, spi_init=0, go to WAIT_TICK.
  - Timeout → timeout_err=1, no capture, go to WAIT_TICK.
  - spi_amp_adc stays 1 until the next AMP_SETUP.
- Sample-rate counter:
  - Runs only while state≠IDLE; counts 0..SAMPLE_DIV-1 and wraps.
  - At terminal count, tick_pending is set.
  - If tick_pending is already set, the tick is dropped and overrun=1.
  - First tick occurs SAMPLE_DIV cycles after leaving IDLE.
- gain_update: sets gain_pending in any state except IDLE. A pulse in IDLE is ignored; the amp is programmed on enable anyway. Multiple pulses collapse to one.
- Capture / output register:
  - On a capture with sample_valid=0, or with sample_valid=1 and sample_ready=1 in the same cycle: sample_data←spi_data, sample_valid=1 next cycle.
  - On a capture with sample_valid=1 and sample_ready=0: new sample discarded, old sample retained, overrun=1.
  - With no capture, sample_valid & sample_ready → sample_valid=0 next cycle.
- Capture latency: sample_valid rises 1 cycle after the spi_init_done sample edge.
- enable falling mid-transaction: the transaction completes or times out, then goes via WAIT_TICK to IDLE. Pending flags clear on entering IDLE. sample_valid and sample_data are retained.
- spi_init_done while not in a RUN state: ignored.
- Async reset mid-transaction drops spi_init immediately.

Test Plan:
- Reset, enable=1, SPI model returns done 40 cycles after Init → spi_amp_adc=0 on the first Init. After done, the first ADC Init (spi_amp_adc=1) starts at cycle SAMPLE_DIV+2 after enable.
- Model returns spi_data=8'hA5, sample_ready=1 → sample_data=8'hA5, sample_valid high exactly 1 cycle, overrun=0.
- sample_ready=0 across two conversions (8'h11 then 8'h22) → sample_data stays 8'h11, overrun=1. Raising ready clears valid; overrun stays 1.
- gain_update pulse during ADC_RUN, with a tick also pending at completion → next transaction has spi_amp_adc=0, the ADC conversion follows immediately after it.
- Model never asserts done, DONE_TIMEOUT=255 → spi_init falls after 255 cycles in RUN, timeout_err=1, sample_valid unchanged, sequencer resumes on the next tick.
- rst low in the middle of ADC_RUN → spi_init=0 and all outputs at reset values asynchronously. After release with enable=1, the amplifier is programmed first.
